mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline, sitting directly upstream of the write-back stage.
- Holds the EX→MEM pipeline register and waits for the data-SRAM response when the instruction is a load.
- Aligns and sign/zero-extends load data.
- Presents pc, rf_waddr, rf_we, res_from_mem, data and alu_result to WB under a valid/allow_in handshake.

Parameters:
- DW, 32, datapath width (fixed at 32; narrower values unsupported).
- RW, 5, register-file address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- ex_valid  input  1  EX stage holds a valid instruction that is ready to leave EX.
- mem_allow_in  output  1  MEM accepts a new instruction this cycle.
- ex_pc  input  32  instruction PC.
- ex_rf_waddr  input  5  destination register.
- ex_rf_we  input  1  register write enable.
- ex_res_from_mem  input  1  instruction is a load.
- ex_ld_op  input  3  load type: 0=W, 1=B, 2=H, 3=BU, 4=HU; 5-7 treated as W.
- ex_alu_result  input  32  ALU result; for loads, the byte address.
- data_sram_data_ok  input  1  load response valid (one-cycle pulse).
- data_sram_rdata  input  32  raw 32-bit word for the aligned address.
- wb_allow_in  input  1  WB accepts an instruction this cycle.
- mem_to_wb_valid  output  1  MEM holds a completed instruction for WB.
- pc  output  32  to WB.
- rf_waddr  output  5  to WB.
- rf_we  output  1  to WB; gated by the stage-valid register.
- res_from_mem  output  1  to WB.
- data  output  32  extended load data.
- alu_result  output  32  to WB.
- MEM_ready_go  output  1  stage work complete.

Behaviour:
- State: mem_valid register, payload registers (pc, waddr, we, res_from_mem, ld_op, alu_result), resp_buf[31:0], resp_buf_v.
- Reset (resetn=0 at a clock edge):
  - mem_valid=0, resp_buf_v=0, all payload registers 0.
  - Outputs after reset: mem_to_wb_valid=0, rf_we=0, pc=0, data=0, alu_result=0.
  - mem_allow_in=1 after reset.
  - Reset mid-load discards the pending response; a data_ok in the reset cycle is ignored.
- Ready and allow:
  - need_resp = mem_valid & res_from_mem.
  - MEM_ready_go = ~need_resp | data_sram_data_ok | resp_buf_v.
  - mem_to_wb_valid = mem_valid & MEM_ready_go.
  - mem_allow_in = ~mem_valid | (MEM_ready_go & wb_allow_in).
- Register update:
  - If mem_allow_in: mem_valid <= ex_valid.
  - If mem_allow_in & ex_valid: latch all ex_* payload.
  - When the payload is not latched, it holds unchanged.
- Response buffer:
  - Set when need_resp & data_sram_data_ok & ~resp_buf_v & ~wb_allow_in; latch rdata into resp_buf.
  - Cleared when the instruction hands off (mem_to_wb_valid & wb_allow_in).
  - Handoff takes priority over set in the same cycle.
- Stray responses: data_ok while ~need_resp, or while resp_buf_v=1, is ignored with no state change.
- Raw word selection: raw = resp_buf_v ? resp_buf : data_sram_rdata.
- Load extraction, with a = alu_result[1:0]:
  - B/BU: byte raw[8a+7:8a], sign-extended for B, zero-extended for BU.
  - H/HU: halfword raw[16a[1]+15:16a[1]], i.e. a[1] selects the upper half; sign- or zero-extended.
  - Misaligned halfword (a[0]=1): use a[1] only; alignment exceptions are not handled here.
  - W: raw passed through.
- Non-load: data = alu_result.
- Output gating: rf_we = mem_valid & we register.
- Simultaneous handoff and accept: in the same edge MEM hands to WB and latches the new EX instruction. No bubble is inserted, so throughput is 1 instr/cycle for non-loads.
- Latency:
  - Non-load: the instruction leaves one cycle after entry.
  - Load: the instruction leaves in the cycle data_ok arrives (or later if WB stalls).

Optional Feature:
- Macro: MEM_FWD_EN.
- When defined, adds these outputs for ID bypass/interlock:
  - mem_fwd_we (1) = mem_valid & we & (waddr≠0).
  - mem_fwd_waddr (5).
  - mem_fwd_data (32) = data.
  - mem_fwd_block (1) = need_resp & ~MEM_ready_go, i.e. load data not yet available; ID must stall on a match.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with ex_valid=1 → mem_to_wb_valid=0, rf_we=0, mem_allow_in=1; first instruction is accepted on the edge after resetn=1.
- Back-to-back non-loads (ALU results 0x11, 0x22, 0x33), wb_allow_in=1 → WB receives data 0x11, 0x22, 0x33 on consecutive cycles; mem_allow_in stays 1.
- ld.b at addr 0x1003, rdata=0x80FF_1234, data_ok 3 cycles after entry:
  - MEM_ready_go=0 and mem_allow_in=0 for 2 cycles.
  - Then data=0xFFFF_FF80.
  - Repeating as ld.bu at the same address → 0x0000_0080.
- ld.h at addr 0x2002, rdata=0x8001_7FFF → data=0xFFFF_8001; ld.hu at addr 0x2000 with the same rdata → 0x0000_7FFF.
- WB stall:
  - Load with data_ok while wb_allow_in=0 (rdata=0xDEAD_BEEF); data_ok drops and rdata changes to 0.
  - Release after 4 cycles → data=0xDEAD_BEEF, resp_buf_v clears at handoff.
  - A stray data_ok during the stall leaves the buffer unchanged.
- MEM_FWD_EN defined: load to r5 pending → mem_fwd_block=1, mem_fwd_waddr=5; on data_ok, block=0 and fwd_data equals the extended data. A write to r0 gives mem_fwd_we=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: EX->MEM pipeline register, load-response wait/buffer, load alignment and extension.
// Optional macro MEM_FWD_EN adds bypass/interlock outputs toward ID.
module mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ex_valid,
  output logic          mem_allow_in,
  input  logic [DW-1:0] ex_pc,
  input  logic [RW-1:0] ex_rf_waddr,
  input  logic          ex_rf_we,
  input  logic          ex_res_from_mem,
  input  logic [2:0]    ex_ld_op,
  input  logic [DW-1:0] ex_alu_result,
  input  logic          data_sram_data_ok,
  input  logic [DW-1:0] data_sram_rdata,
  input  logic          wb_allow_in,
  output logic          mem_to_wb_valid,
  output logic [DW-1:0] pc,
  output logic [RW-1:0] rf_waddr,
  output logic          rf_we,
  output logic          res_from_mem,
  output logic [DW-1:0] data,
  output logic [DW-1:0] alu_result,
`ifdef MEM_FWD_EN
  output logic          mem_fwd_we,
  output logic [RW-1:0] mem_fwd_waddr,
  output logic [DW-1:0] mem_fwd_data,
  output logic          mem_fwd_block,
`endif
  output logic          MEM_ready_go
);

  logic          mem_valid_q, mem_valid_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [RW-1:0] waddr_q, waddr_d;
  logic          we_q, we_d;
  logic          res_from_mem_q, res_from_mem_d;
  logic [2:0]    ld_op_q, ld_op_d;
  logic [DW-1:0] alu_result_q, alu_result_d;
  logic [DW-1:0] resp_buf_q, resp_buf_d;
  logic          resp_buf_v_q, resp_buf_v_d;

  logic          need_resp;
  logic          handoff;
  logic [DW-1:0] raw;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_data;

  assign need_resp       = mem_valid_q & res_from_mem_q;
  assign MEM_ready_go    = ~need_resp | data_sram_data_ok | resp_buf_v_q;
  assign mem_to_wb_valid = mem_valid_q & MEM_ready_go;
  assign mem_allow_in    = ~mem_valid_q | (MEM_ready_go & wb_allow_in);
  assign handoff         = mem_to_wb_valid & wb_allow_in;

  // Once buffered, the live SRAM bus is ignored until this instruction leaves.
  assign raw = resp_buf_v_q ? resp_buf_q : data_sram_rdata;

  always_comb begin
    byte_sel = raw[7:0];
    case (alu_result_q[1:0])
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      2'd3:    byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = alu_result_q[1] ? raw[31:16] : raw[15:0];
    case (ld_op_q)
      3'd1:    load_data = {{(DW-8){byte_sel[7]}}, byte_sel};
      3'd2:    load_data = {{(DW-16){half_sel[15]}}, half_sel};
      3'd3:    load_data = {{(DW-8){1'b0}}, byte_sel};
      3'd4:    load_data = {{(DW-16){1'b0}}, half_sel};
      default: load_data = raw;
    endcase
  end

  always_comb begin
    mem_valid_d    = mem_valid_q;
    pc_d           = pc_q;
    waddr_d        = waddr_q;
    we_d           = we_q;
    res_from_mem_d = res_from_mem_q;
    ld_op_d        = ld_op_q;
    alu_result_d   = alu_result_q;
    resp_buf_d     = resp_buf_q;
    resp_buf_v_d   = resp_buf_v_q;

    if (mem_allow_in) begin
      mem_valid_d = ex_valid;
    end
    if (mem_allow_in && ex_valid) begin
      pc_d           = ex_pc;
      waddr_d        = ex_rf_waddr;
      we_d           = ex_rf_we;
      res_from_mem_d = ex_res_from_mem;
      ld_op_d        = ex_ld_op;
      alu_result_d   = ex_alu_result;
    end

    // Capture only when WB is stalled; handoff wins over a same-cycle capture.
    if (handoff) begin
      resp_buf_v_d = 1'b0;
    end else if (need_resp && data_sram_data_ok && !resp_buf_v_q && !wb_allow_in) begin
      resp_buf_v_d = 1'b1;
      resp_buf_d   = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_q    <= 1'b0;
      pc_q           <= '0;
      waddr_q        <= '0;
      we_q           <= 1'b0;
      res_from_mem_q <= 1'b0;
      ld_op_q        <= '0;
      alu_result_q   <= '0;
      resp_buf_q     <= '0;
      resp_buf_v_q   <= 1'b0;
    end else begin
      mem_valid_q    <= mem_valid_d;
      pc_q           <= pc_d;
      waddr_q        <= waddr_d;
      we_q           <= we_d;
      res_from_mem_q <= res_from_mem_d;
      ld_op_q        <= ld_op_d;
      alu_result_q   <= alu_result_d;
      resp_buf_q     <= resp_buf_d;
      resp_buf_v_q   <= resp_buf_v_d;
    end
  end

  assign pc           = pc_q;
  assign rf_waddr     = waddr_q;
  assign rf_we        = mem_valid_q & we_q;
  assign res_from_mem = res_from_mem_q;
  assign alu_result   = alu_result_q;
  assign data         = res_from_mem_q ? load_data : alu_result_q;

`ifdef MEM_FWD_EN
  assign mem_fwd_we    = mem_valid_q & we_q & (waddr_q != '0);
  assign mem_fwd_waddr = waddr_q;
  assign mem_fwd_data  = data;
  assign mem_fwd_block = need_resp & ~MEM_ready_go;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load-extraction vector table plus hand-written
// reset, back-to-back, WB-stall and reset-mid-load sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic        mem_allow_in;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rf_waddr;
  logic        ex_rf_we;
  logic        ex_res_from_mem;
  logic [2:0]  ex_ld_op;
  logic [31:0] ex_alu_result;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allow_in;
  logic        mem_to_wb_valid;
  logic [31:0] pc;
  logic [4:0]  rf_waddr;
  logic        rf_we;
  logic        res_from_mem;
  logic [31:0] data;
  logic [31:0] alu_result;
  logic        MEM_ready_go;
`ifdef MEM_FWD_EN
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_waddr;
  logic [31:0] mem_fwd_data;
  logic        mem_fwd_block;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .mem_allow_in(mem_allow_in),
    .ex_pc(ex_pc), .ex_rf_waddr(ex_rf_waddr), .ex_rf_we(ex_rf_we),
    .ex_res_from_mem(ex_res_from_mem), .ex_ld_op(ex_ld_op), .ex_alu_result(ex_alu_result),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allow_in(wb_allow_in), .mem_to_wb_valid(mem_to_wb_valid),
    .pc(pc), .rf_waddr(rf_waddr), .rf_we(rf_we), .res_from_mem(res_from_mem),
    .data(data), .alu_result(alu_result),
`ifdef MEM_FWD_EN
    .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr),
    .mem_fwd_data(mem_fwd_data), .mem_fwd_block(mem_fwd_block),
`endif
    .MEM_ready_go(MEM_ready_go)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else begin
      n_pass++;
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic rfm, input logic [2:0] op, input logic [31:0] addr,
                       input logic [4:0] wa, input logic [31:0] pcv);
    ex_valid = 1'b1; ex_res_from_mem = rfm; ex_ld_op = op; ex_alu_result = addr;
    ex_rf_waddr = wa; ex_rf_we = 1'b1; ex_pc = pcv;
  endtask

  typedef struct {
    string       name;
    logic        rfm;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{"ld.b 1003",   1'b1, 3'd1, 32'h1003, 32'h80FF_1234, 2, 32'hFFFF_FF80};
    vecs[1]  = '{"ld.bu 1003",  1'b1, 3'd3, 32'h1003, 32'h80FF_1234, 2, 32'h0000_0080};
    vecs[2]  = '{"ld.h 2002",   1'b1, 3'd2, 32'h2002, 32'h8001_7FFF, 1, 32'hFFFF_8001};
    vecs[3]  = '{"ld.hu 2000",  1'b1, 3'd4, 32'h2000, 32'h8001_7FFF, 0, 32'h0000_7FFF};
    vecs[4]  = '{"ld.w 3000",   1'b1, 3'd0, 32'h3000, 32'hCAFE_F00D, 1, 32'hCAFE_F00D};
    vecs[5]  = '{"ld.b 1000",   1'b1, 3'd1, 32'h1000, 32'h80FF_1234, 0, 32'h0000_0034};
    vecs[6]  = '{"ld.b 1001",   1'b1, 3'd1, 32'h1001, 32'h80FF_1234, 0, 32'h0000_0012};
    vecs[7]  = '{"ld.bu 1002",  1'b1, 3'd3, 32'h1002, 32'h80FF_1234, 0, 32'h0000_00FF};
    vecs[8]  = '{"ld.b 1002",   1'b1, 3'd1, 32'h1002, 32'h80FF_1234, 0, 32'hFFFF_FFFF};
    vecs[9]  = '{"ld.h mis 2003", 1'b1, 3'd2, 32'h2003, 32'h8001_7FFF, 0, 32'hFFFF_8001};
    vecs[10] = '{"ld.hu mis 2001", 1'b1, 3'd4, 32'h2001, 32'h8001_7FFF, 0, 32'h0000_7FFF};
    vecs[11] = '{"ld op5 as W", 1'b1, 3'd5, 32'h3001, 32'h1234_5678, 0, 32'h1234_5678};
    vecs[12] = '{"ld op7 as W", 1'b1, 3'd7, 32'h3002, 32'h8765_4321, 0, 32'h8765_4321};
    vecs[13] = '{"non-load",    1'b0, 3'd1, 32'hABCD_0001, 32'h0000_0000, 0, 32'hABCD_0001};

    // Reset held two cycles with a valid EX instruction and a stray data_ok.
    resetn = 1'b0; wb_allow_in = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0;
    drive(1'b0, 3'd0, 32'h55, 5'd3, 32'h100);
    tick(); tick(); #1;
    chk("rst valid", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("rst rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst allow_in", {31'd0, mem_allow_in}, 32'd1);
    chk("rst pc", pc, 32'd0);
    chk("rst data", data, 32'd0);
    chk("rst alu_result", alu_result, 32'd0);
    resetn = 1'b1; data_sram_data_ok = 1'b0;
    tick(); #1;
    chk("first valid", {31'd0, mem_to_wb_valid}, 32'd1);
    chk("first data", data, 32'h55);
    chk("first pc", pc, 32'h100);
    chk("first rf_we", {31'd0, rf_we}, 32'd1);
    chk("first waddr", {27'd0, rf_waddr}, 32'd3);

    // Back-to-back non-loads: hand off and accept on the same edge.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 3'd0, 32'h11 * i, 5'd4, 32'h200 + 4 * i);
      tick(); #1;
      chk($sformatf("b2b%0d valid", i), {31'd0, mem_to_wb_valid}, 32'd1);
      chk($sformatf("b2b%0d data", i), data, 32'h11 * i);
      chk($sformatf("b2b%0d allow_in", i), {31'd0, mem_allow_in}, 32'd1);
    end
    ex_valid = 1'b0;
    tick(); #1;
    chk("b2b drained", {31'd0, mem_to_wb_valid}, 32'd0);

    // Table-driven loads and a non-load.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rfm, vecs[i].op, vecs[i].addr, 5'd9, 32'h3000 + 4 * i);
      tick();
      ex_valid = 1'b0;
      for (int d = 0; d < vecs[i].dly; d++) begin
        #1;
        chk({vecs[i].name, " wait ready_go"}, {31'd0, MEM_ready_go}, 32'd0);
        chk({vecs[i].name, " wait allow_in"}, {31'd0, mem_allow_in}, 32'd0);
        tick();
      end
      if (vecs[i].rfm) begin
        data_sram_data_ok = 1'b1; data_sram_rdata = vecs[i].rdata;
      end
      #1;
      chk({vecs[i].name, " valid"}, {31'd0, mem_to_wb_valid}, 32'd1);
      chk({vecs[i].name, " data"}, data, vecs[i].exp);
      chk({vecs[i].name, " res_from_mem"}, {31'd0, res_from_mem}, {31'd0, vecs[i].rfm});
      tick();
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      #1;
      chk({vecs[i].name, " left"}, {31'd0, mem_to_wb_valid}, 32'd0);
    end

    // WB stall: response buffered, stray data_ok ignored, release after 4 cycles.
    wb_allow_in = 1'b0;
    drive(1'b1, 3'd0, 32'h4000, 5'd7, 32'h400);
    tick();
    ex_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("stall ok valid", {31'd0, mem_to_wb_valid}, 32'd1);
    chk("stall allow_in", {31'd0, mem_allow_in}, 32'd0);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    #1;
    chk("stall buf data", data, 32'hDEAD_BEEF);
    chk("stall buf valid", {31'd0, mem_to_wb_valid}, 32'd1);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
    #1;
    chk("stray ok data", data, 32'hDEAD_BEEF);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    #1;
    chk("after stray data", data, 32'hDEAD_BEEF);
    tick();
    wb_allow_in = 1'b1;
    #1;
    chk("release valid", {31'd0, mem_to_wb_valid}, 32'd1);
    chk("release allow_in", {31'd0, mem_allow_in}, 32'd1);
    chk("release data", data, 32'hDEAD_BEEF);
    tick(); #1;
    chk("release left", {31'd0, mem_to_wb_valid}, 32'd0);
    // A stale buffer would make the next load look ready immediately.
    drive(1'b1, 3'd0, 32'h4004, 5'd7, 32'h404);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("buf cleared ready_go", {31'd0, MEM_ready_go}, 32'd0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
    #1;
    chk("post-stall load data", data, 32'h0BAD_F00D);
    tick();
    data_sram_data_ok = 1'b0;

    // Reset mid-load with data_ok in the reset cycle.
    wb_allow_in = 1'b0;
    drive(1'b1, 3'd1, 32'h5000, 5'd8, 32'h500);
    tick();
    ex_valid = 1'b0; resetn = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FFFF;
    tick();
    resetn = 1'b1; data_sram_data_ok = 1'b0; wb_allow_in = 1'b1;
    #1;
    chk("rst mid valid", {31'd0, mem_to_wb_valid}, 32'd0);
    chk("rst mid allow_in", {31'd0, mem_allow_in}, 32'd1);
    drive(1'b1, 3'd0, 32'h5004, 5'd8, 32'h504);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("rst mid no buf", {31'd0, MEM_ready_go}, 32'd0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_00AA;
    tick();
    data_sram_data_ok = 1'b0;

`ifdef MEM_FWD_EN
    drive(1'b1, 3'd1, 32'h6001, 5'd5, 32'h600);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("fwd block", {31'd0, mem_fwd_block}, 32'd1);
    chk("fwd waddr", {27'd0, mem_fwd_waddr}, 32'd5);
    chk("fwd we", {31'd0, mem_fwd_we}, 32'd1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_F000;
    #1;
    chk("fwd unblock", {31'd0, mem_fwd_block}, 32'd0);
    chk("fwd data", mem_fwd_data, 32'hFFFF_FFF0);
    tick();
    data_sram_data_ok = 1'b0;
    drive(1'b0, 3'd0, 32'h77, 5'd0, 32'h604);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("fwd r0 we", {31'd0, mem_fwd_we}, 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
